life_view_renderer: RTL and testbench

Parametrised successor to the first renderer. Generates XVGA-style timing, fetches board words from the cell memory and paints a scrollable, zoomable viewport of the Game of Life board. Adds parametrised timing, a fixed-latency memory pipeline, toroidal wrap-around, power-of-two zoom, an optional grid overlay and a per-frame done pulse. The life engine uses that pulse to swap buffers.

---
 rtl/life_pkg.sv | 35 +++
 rtl/life_view_renderer_if.sv | 14 +
 rtl/vga_timing.sv | 58 +++++
 rtl/life_view_renderer.sv | 194 +++++++++++++++++++
 tb/tb_life_view_renderer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life viewport renderer.
//   rgb_t     : 12-bit RGB444 pixel
//   timing_t  : active/porch/sync widths of one video axis
//   state_t   : renderer FSM states
//   log2      : ceiling log2, used to size counters and address fields
package life_pkg;

  typedef logic [11:0] rgb_t;

  localparam rgb_t ALIVE_COLOR_DEFAULT = 12'hFFF;
  localparam rgb_t DEAD_COLOR_DEFAULT  = 12'h000;
  localparam rgb_t GRID_COLOR_DEFAULT  = 12'h333;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } timing_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/life_view_renderer_if.sv
// Cell-memory read bus between the renderer (master) and the board memory
// (slave).
//   addr_r_out : word address issued by the renderer
//   data_r_in  : word returned by the memory a fixed number of cycles later
interface life_view_renderer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr_r_out;
  logic [DATA_W-1:0] data_r_in;

  modport master (output addr_r_out, input data_r_in);
  modport slave  (input addr_r_out, output data_r_in);
endinterface

// File: rtl/vga_timing.sv
// Free-running raster counters with raw (undelayed) sync and blank.
//   clk_in, rst_in : pixel clock, asynchronous active-high reset
//   en             : counters run while high, are held at 0 while low
//   hcount, vcount : current raster position
//   hsync_raw, vsync_raw : active-low syncs decoded from the counters
//   blank_raw      : high outside the visible area
module vga_timing
  import life_pkg::*;
#(
  parameter timing_t H_T = '{active: 16'd1024, fp: 16'd24, sync: 16'd136, bp: 16'd160},
  parameter timing_t V_T = '{active: 16'd768, fp: 16'd3, sync: 16'd6, bp: 16'd29},
  parameter int HW = log2(int'(H_T.active) + int'(H_T.fp) + int'(H_T.sync) + int'(H_T.bp)),
  parameter int VW = log2(int'(V_T.active) + int'(V_T.fp) + int'(V_T.sync) + int'(V_T.bp))
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          en,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          blank_raw
);

  localparam int H_SS_I = int'(H_T.active) + int'(H_T.fp);
  localparam int V_SS_I = int'(V_T.active) + int'(V_T.fp);
  localparam int H_SE_I = H_SS_I + int'(H_T.sync);
  localparam int V_SE_I = V_SS_I + int'(V_T.sync);

  localparam logic [HW-1:0] H_LAST = HW'(H_SE_I + int'(H_T.bp) - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_SE_I + int'(V_T.bp) - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(int'(H_T.active));
  localparam logic [VW-1:0] V_ACT  = VW'(int'(V_T.active));
  localparam logic [HW-1:0] H_SS   = HW'(H_SS_I);
  localparam logic [HW-1:0] H_SE   = HW'(H_SE_I);
  localparam logic [VW-1:0] V_SS   = VW'(V_SS_I);
  localparam logic [VW-1:0] V_SE   = VW'(V_SE_I);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!en) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  assign hsync_raw = !((hcount >= H_SS) && (hcount < H_SE));
  assign vsync_raw = !((vcount >= V_SS) && (vcount < V_SE));
  assign blank_raw = (hcount >= H_ACT) || (vcount >= V_ACT);

endmodule

// File: rtl/life_view_renderer.sv
// Scrollable, zoomable Game of Life viewport renderer.
//   clk_in, rst_in  : pixel clock, asynchronous active-high reset
//   start_in        : leaves IDLE and starts free-running frame generation
//   view_x_in/_y_in : top-left board cell of the viewport (latched per frame)
//   zoom_in         : pixels per cell = 1 << zoom_in (latched per frame)
//   grid_en_in      : grid overlay enable (latched per frame, needs zoom >= 2)
//   mem             : cell-memory read bus (address out, word in)
//   done_out        : one-cycle pulse as blank rises after the last visible pixel
//   pix_out         : RGB444 pixel; hsync_out/vsync_out active low; blank_out
// Pixel path: counters -> address register -> memory (READ_LATENCY) -> output
// register, so every output lags its counter value by READ_LATENCY+2 cycles.
module life_view_renderer
  import life_pkg::*;
#(
  parameter int   H_ACTIVE     = 1024,
  parameter int   H_FP         = 24,
  parameter int   H_SYNC       = 136,
  parameter int   H_BP         = 160,
  parameter int   V_ACTIVE     = 768,
  parameter int   V_FP         = 3,
  parameter int   V_SYNC       = 6,
  parameter int   V_BP         = 29,
  parameter int   LINE_WIDTH   = 32,
  parameter int   LOG_BOARD_W  = 10,
  parameter int   LOG_BOARD_H  = 10,
  parameter int   READ_LATENCY = 2,
  parameter rgb_t ALIVE_COLOR  = ALIVE_COLOR_DEFAULT,
  parameter rgb_t DEAD_COLOR   = DEAD_COLOR_DEFAULT,
  parameter rgb_t GRID_COLOR   = GRID_COLOR_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [LOG_BOARD_W-1:0] view_x_in,
  input  logic [LOG_BOARD_H-1:0] view_y_in,
  input  logic [1:0]             zoom_in,
  input  logic                   grid_en_in,
  life_view_renderer_if.master   mem,
  output logic                   done_out,
  output rgb_t                   pix_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   blank_out
);

  localparam int BI = log2(LINE_WIDTH);
  localparam int HW = log2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = log2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam logic [HW-1:0] H_AFTER_LAST = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST_VIS   = VW'(V_ACTIVE - 1);

  // Per-pixel side information travelling alongside the memory read.
  typedef struct packed {
    logic          valid;
    logic [BI-1:0] bit_idx;
    logic          grid;
    logic          blank;
    logic          hsync;
    logic          vsync;
    logic          last;
  } tag_t;

  state_t state;
  logic   run;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_in) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign run = (state == ST_RUN);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync_raw, vsync_raw, blank_raw;

  vga_timing #(.H_T(H_T), .V_T(V_T), .HW(HW), .VW(VW)) u_timing (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (run),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .blank_raw (blank_raw)
  );

  // Frame latch. At the origin the live inputs are used directly so the very
  // first pixel of a frame already sees the new view settings.
  logic                   origin;
  logic [LOG_BOARD_W-1:0] view_x_reg, view_x_eff;
  logic [LOG_BOARD_H-1:0] view_y_reg, view_y_eff;
  logic [1:0]             zoom_reg, zoom_eff;
  logic                   grid_reg, grid_eff;

  assign origin = run && (hcount == '0) && (vcount == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      view_x_reg <= '0;
      view_y_reg <= '0;
      zoom_reg   <= '0;
      grid_reg   <= 1'b0;
    end else if (origin) begin
      view_x_reg <= view_x_in;
      view_y_reg <= view_y_in;
      zoom_reg   <= zoom_in;
      grid_reg   <= grid_en_in;
    end
  end

  assign view_x_eff = origin ? view_x_in  : view_x_reg;
  assign view_y_eff = origin ? view_y_in  : view_y_reg;
  assign zoom_eff   = origin ? zoom_in    : zoom_reg;
  assign grid_eff   = origin ? grid_en_in : grid_reg;

  // Stage 0: board cell under the beam; the sum truncates to the board size,
  // which is exactly the toroidal wrap.
  logic [LOG_BOARD_W-1:0] cell_x;
  logic [LOG_BOARD_H-1:0] cell_y;
  logic [HW-1:0]          hmask;
  logic [VW-1:0]          vmask;
  tag_t                   tag0;

  always_comb begin
    cell_x = view_x_eff + LOG_BOARD_W'(hcount >> zoom_eff);
    cell_y = view_y_eff + LOG_BOARD_H'(vcount >> zoom_eff);
    hmask  = (HW'(1) << zoom_eff) - HW'(1);
    vmask  = (VW'(1) << zoom_eff) - VW'(1);
    tag0         = '0;
    tag0.valid   = run;
    tag0.bit_idx = cell_x[BI-1:0];
    tag0.grid    = grid_eff && (zoom_eff >= 2'd2) &&
                   (((hcount & hmask) == '0) || ((vcount & vmask) == '0));
    tag0.blank   = blank_raw;
    tag0.hsync   = hsync_raw;
    tag0.vsync   = vsync_raw;
    tag0.last    = (hcount == H_AFTER_LAST) && (vcount == V_LAST_VIS);
  end

  // Stage 1 address register plus the tag shift register; pipe[READ_LATENCY]
  // lines up with the word on data_r_in.
  tag_t pipe [0:READ_LATENCY];
  tag_t tail;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem.addr_r_out <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      mem.addr_r_out <= run ? {cell_y, cell_x[LOG_BOARD_W-1:BI]} : '0;
      pipe[0] <= tag0;
      for (int i = 1; i <= READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[READ_LATENCY];

  // Output register; invalid slots (IDLE or pipeline still filling) show the
  // reset values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
      done_out  <= 1'b0;
    end else if (!tail.valid) begin
      pix_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
      done_out  <= 1'b0;
    end else begin
      hsync_out <= tail.hsync;
      vsync_out <= tail.vsync;
      blank_out <= tail.blank;
      done_out  <= tail.last;
      if (tail.blank)                       pix_out <= '0;
      else if (tail.grid)                   pix_out <= GRID_COLOR;
      else if (mem.data_r_in[tail.bit_idx]) pix_out <= ALIVE_COLOR;
      else                                  pix_out <= DEAD_COLOR;
    end
  end

endmodule

// File: tb/tb_life_view_renderer.sv
// Directed bench for life_view_renderer using a reduced raster so full frames
// fit in a short run. A reference model predicts each cycle's video outputs
// into a queue; entries are popped once the pipeline latency has elapsed.
module tb_life_view_renderer;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int L = 2;

  typedef logic [15:0] vid_t;  // {pix, hsync, vsync, blank, done}

  logic        clk;
  logic        rst_in;
  logic        start_in;
  logic [9:0]  view_x_in;
  logic [9:0]  view_y_in;
  logic [1:0]  zoom_in;
  logic        grid_en_in;
  logic        done_out;
  logic [11:0] pix_out;
  logic        hsync_out, vsync_out, blank_out;

  life_view_renderer_if #(.ADDR_W(15), .DATA_W(32)) mif ();

  life_view_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_WIDTH(32), .LOG_BOARD_W(10), .LOG_BOARD_H(10), .READ_LATENCY(L)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .view_x_in  (view_x_in),
    .view_y_in  (view_y_in),
    .zoom_in    (zoom_in),
    .grid_en_in (grid_en_in),
    .mem        (mif),
    .done_out   (done_out),
    .pix_out    (pix_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory with a fixed read latency of L cycles.
  logic [31:0] mem_arr [0:32767];
  logic [31:0] rd_pipe [0:L-1];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_arr[mif.addr_r_out];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mif.data_r_in = rd_pipe[L-1];

  // Model state
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_count = 0;
  int          mh = 0, mv = 0;
  bit          running = 0;
  logic [9:0]  lx = '0, ly = '0;
  logic [1:0]  lz = '0;
  bit          lg = 0;
  logic [14:0] addr_exp = '0;
  vid_t        q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (model h=%0d v=%0d)", tag, obs, exp_v, mh, mv);
    end
  endtask

  function automatic vid_t reset_vid();
    return {12'h000, 1'b1, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic logic [9:0] cell_x_of(input int h);
    return 10'(int'(lx) + (h >> lz));
  endfunction

  function automatic logic [9:0] cell_y_of(input int v);
    return 10'(int'(ly) + (v >> lz));
  endfunction

  function automatic vid_t model_vid(input int h, input int v);
    logic [9:0]  cx, cy;
    logic [31:0] w;
    logic [11:0] pix;
    bit          blank, hs, vs, done, grid;
    int          z;
    z     = 1 << lz;
    cx    = cell_x_of(h);
    cy    = cell_y_of(v);
    w     = mem_arr[{cy, cx[9:5]}];
    blank = (h >= HA) || (v >= VA);
    hs    = !((h >= HA + HF) && (h < HA + HF + HS));
    vs    = !((v >= VA + VF) && (v < VA + VF + VS));
    done  = (h == HA) && (v == VA - 1);
    grid  = lg && (lz >= 2) && (((h % z) == 0) || ((v % z) == 0));
    if (blank)          pix = 12'h000;
    else if (grid)      pix = 12'h333;
    else if (w[cx[4:0]]) pix = 12'hFFF;
    else                pix = 12'h000;
    return {pix, hs, vs, blank, done};
  endfunction

  task automatic set_cell(input int x, input int y, input bit val);
    logic [9:0] xx, yy;
    xx = 10'(x);
    yy = 10'(y);
    mem_arr[{yy, xx[9:5]}][xx[4:0]] = val;
  endtask

  // One clock cycle: predict at the falling edge, compare just after the rising edge.
  task automatic step();
    vid_t       got;
    vid_t       exp_v;
    logic [9:0] cx, cy;
    @(negedge clk);
    if (running) begin
      if (mh == 0 && mv == 0) begin
        lx = view_x_in; ly = view_y_in; lz = zoom_in; lg = grid_en_in;
      end
      q.push_back(model_vid(mh, mv));
      cx = cell_x_of(mh);
      cy = cell_y_of(mv);
      addr_exp = {cy, cx[9:5]};
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    @(posedge clk);
    #1;
    got = {pix_out, hsync_out, vsync_out, blank_out, done_out};
    if (running) begin
      if (q.size() > L + 1) begin
        exp_v = q.pop_front();
        check("video", 32'(got), 32'(exp_v));
      end
      check("addr", 32'(mif.addr_r_out), 32'(addr_exp));
    end else begin
      check("idle_video", 32'(got), 32'(reset_vid()));
      check("idle_addr", 32'(mif.addr_r_out), 32'd0);
    end
    if (done_out) done_count++;
  endtask

  task automatic start_frame();
    @(negedge clk);
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    running = 1;
    mh = 0;
    mv = 0;
    done_count = 0;
    q.delete();
    repeat (L + 1) q.push_back(reset_vid());
  endtask

  task automatic stop_model();
    running = 0;
    q.delete();
  endtask

  initial begin
    rst_in = 1'b1;
    start_in = 1'b0;
    view_x_in = '0;
    view_y_in = '0;
    zoom_in = '0;
    grid_en_in = 1'b0;
    for (int i = 0; i < 32768; i++) mem_arr[i] = '0;

    // Reset, then idle without start: reset values, no done pulse
    repeat (3) step();
    rst_in = 1'b0;
    repeat (6) step();
    check("done_before_start", 32'(done_count), 32'd0);

    // Single live cell at (0,0), zoom 0: two full frames
    set_cell(0, 0, 1'b1);
    start_frame();
    repeat (2 * FRAME) step();
    check("done_per_2_frames_a", 32'(done_count), 32'd2);

    // Asynchronous reset mid-line (visible area, line 2)
    repeat (56) step();
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_video", 32'({pix_out, hsync_out, vsync_out, blank_out, done_out}),
          32'(reset_vid()));
    check("async_rst_addr", 32'(mif.addr_r_out), 32'd0);
    stop_model();
    repeat (3) step();
    rst_in = 1'b0;
    repeat (10) step();

    // Zoom 2 with cell (1,0); grid enabled mid-frame takes effect next frame
    set_cell(0, 0, 1'b0);
    set_cell(1, 0, 1'b1);
    zoom_in = 2'd2;
    grid_en_in = 1'b0;
    start_frame();
    repeat (100) step();
    grid_en_in = 1'b1;
    repeat (2 * FRAME - 100) step();
    check("done_per_2_frames_b", 32'(done_count), 32'd2);
    rst_in = 1'b1;
    stop_model();
    repeat (2) step();
    rst_in = 1'b0;
    repeat (4) step();

    // Wrap-around: view_x 1020 shows cell 2 at x = 6; view change mid-frame
    // and a stray start pulse during RUN
    set_cell(2, 0, 1'b1);
    view_x_in = 10'd1020;
    zoom_in = 2'd0;
    grid_en_in = 1'b0;
    start_frame();
    repeat (150) step();
    view_x_in = 10'd0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (2 * FRAME - 151) step();
    check("done_per_2_frames_c", 32'(done_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
